ofdm_symbol_sched: RTL and testbench

// - Sequences the time-synchronised sample stream from Synch into OFDM symbols for the FFT.
// - Per frame: discards each cyclic prefix (NCP samples), forwards the NFFT-sample useful part, and

---
 rtl/ofdm_rx_pkg.sv | 11 +
 rtl/wb_stream_reg.sv | 34 +++
 rtl/ofdm_symbol_sched.sv | 123 ++++++++++++
 tb/tb_ofdm_symbol_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ofdm_rx_pkg.sv
// ofdm_rx_pkg: shared OFDM RX frame parameters, sample type and scheduler states
package ofdm_rx_pkg;
  localparam int NFFT = 2048;
  localparam int NCP = 512;
  localparam int NSYM = 6;
  typedef struct packed {
    logic signed [15:0] im;
    logic signed [15:0] re;
  } sample_t;
  typedef enum logic [2:0] {IDLE, CP, SYM, FLUSH, DRAIN} state_t;
endpackage

// File: rtl/wb_stream_reg.sv
// wb_stream_reg: single-entry stream output register, ready whenever empty or draining
module wb_stream_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  input  logic         ack_i,
  output logic         stb_o,
  output logic [W-1:0] q_o,
  output logic         rdy_o
);
  logic         stb_q, stb_d;
  logic [W-1:0] q_q, q_d;
  assign rdy_o = !stb_q || ack_i;
  assign stb_o = stb_q;
  assign q_o   = q_q;
  // load wins; otherwise an accept empties the register and the payload holds
  always_comb begin
    stb_d = ld_i ? 1'b1 : (ack_i ? 1'b0 : stb_q);
    q_d   = ld_i ? d_i : q_q;
  end
  // register state
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q <= 1'b0;
      q_q   <= '0;
    end else begin
      stb_q <= stb_d;
      q_q   <= q_d;
    end
  end
endmodule

// File: rtl/ofdm_symbol_sched.sv
// ofdm_symbol_sched: strips cyclic prefixes and frames NSYM useful symbols for the FFT
module ofdm_symbol_sched
  import ofdm_rx_pkg::*;
#(
  parameter int NFFT_P = NFFT,
  parameter int NCP_P  = NCP,
  parameter int NSYM_P = NSYM,
  parameter int CNT_W  = 12,
  parameter int SYM_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic [31:0]      dat_i,
  output logic             ack_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [31:0]      dat_o,
  input  logic             ack_i,
  output logic             sym_first,
  output logic [SYM_W-1:0] sym_idx,
  output logic             frame_done,
  output logic             frame_err
);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   scnt_q, scnt_d;
  logic [SYM_W-1:0]   sym_q, sym_d, sym_nx;
  logic               cyc_q, cyc_d, err_q, err_d, prev_q;
  logic               rdy, ld, ack;
  sample_t            smp;
  logic [SYM_W+32:0]  pay;
  assign smp    = dat_i;
  assign sym_nx = sym_q + SYM_W'(1);
  assign ack_o  = ack;
  assign cyc_o  = cyc_q;
  assign we_o   = cyc_q;
  assign frame_err  = err_q;
  assign frame_done = (state_q == FLUSH) && rdy && (sym_q == SYM_W'(NSYM_P));
  assign {sym_first, sym_idx, dat_o} = pay;
  wb_stream_reg #(.W(SYM_W + 33)) u_oreg (
    .clk  (clk),
    .rst  (rst),
    .ld_i (ld),
    .d_i  ({scnt_q == '0, sym_q, smp}),
    .ack_i(ack_i),
    .stb_o(stb_o),
    .q_o  (pay),
    .rdy_o(rdy)
  );
  // frame sequencing: prefix discard, symbol forwarding, flush and drain
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    sym_d   = sym_q;
    cyc_d   = cyc_q;
    err_d   = 1'b0;
    ack     = 1'b0;
    ld      = 1'b0;
    case (state_q)
      IDLE: if (cyc_i && !prev_q) begin
        state_d = CP;
        cyc_d   = 1'b1;
        scnt_d  = '0;
        sym_d   = '0;
      end
      CP: begin
        ack = 1'b1;
        if (!cyc_i) begin
          err_d   = 1'b1;
          state_d = FLUSH;
        end else if (stb_i) begin
          scnt_d  = (scnt_q == CNT_W'(NCP_P - 1)) ? '0 : scnt_q + CNT_W'(1);
          state_d = (scnt_q == CNT_W'(NCP_P - 1)) ? SYM : CP;
        end
      end
      SYM: begin
        ack = rdy;
        if (!cyc_i) begin
          err_d   = 1'b1;
          state_d = FLUSH;
        end else if (stb_i && rdy) begin
          ld = 1'b1;
          if (scnt_q == CNT_W'(NFFT_P - 1)) begin
            scnt_d  = '0;
            sym_d   = sym_nx;
            state_d = (sym_nx < SYM_W'(NSYM_P)) ? CP : FLUSH;
          end else begin
            scnt_d = scnt_q + CNT_W'(1);
          end
        end
      end
      FLUSH: if (rdy) begin
        cyc_d   = 1'b0;
        state_d = cyc_i ? DRAIN : IDLE;
      end
      DRAIN: begin
        ack     = 1'b1;
        state_d = cyc_i ? DRAIN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; prev_q resets high so a frame only opens after cyc_i is seen low
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      sym_q   <= '0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      sym_q   <= sym_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      prev_q  <= cyc_i;
    end
  end
endmodule

// File: tb/tb_ofdm_symbol_sched.sv
// tb_ofdm_symbol_sched: scoreboard bench for prefix removal, backpressure, abort, drain and reset
module tb_ofdm_symbol_sched;
  logic        clk = 0, rst = 1, cyc_i = 0, stb_i = 0, ack_i = 0;
  logic [31:0] dat_i = 0;
  logic        ack_o, cyc_o, stb_o, we_o, sym_first, frame_done, frame_err;
  logic [31:0] dat_o;
  logic [3:0]  sym_idx;
  typedef struct {
    logic [31:0] d;
    logic        f;
    logic [3:0]  s;
  } exp_t;
  exp_t        q[$];
  int          total = 0, bad = 0;
  int          outs, dones, errs, drains;
  int          ack_pct = 100, stall_pct = 0;
  logic        cur_useful = 0, hold_v = 0;
  logic [31:0] hold_d = 0;

  ofdm_symbol_sched dut (
    .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .dat_i(dat_i), .ack_o(ack_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .dat_o(dat_o), .ack_i(ack_i),
    .sym_first(sym_first), .sym_idx(sym_idx), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    ack_i = ($urandom_range(99) < ack_pct);
  end

  initial forever begin
    @(negedge clk);
    if (rst) hold_v = 0;
    else begin
      if (hold_v) begin
        chk("hold_stb", stb_o, 1);
        chk("hold_dat", dat_o, hold_d);
      end
      if (stb_o && ack_i) begin
        outs++;
        chk("extra_out", q.size() == 0, 0);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("dat", dat_o, e.d);
          chk("first", sym_first, e.f);
          chk("idx", sym_idx, e.s);
        end
      end
      if (frame_done) begin
        dones++;
        chk("done_pos", outs, 12288);
      end
      if (frame_err) errs++;
      if (cyc_i && stb_i && ack_o && !cyc_o) drains++;
      if (cyc_i && stb_i && ack_o && cur_useful) chk("overrun", stb_o && !ack_i, 0);
      chk("we_eq_cyc", we_o, cyc_o);
      hold_v = stb_o && !ack_i;
      hold_d = dat_o;
    end
  end

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      dat_i = 32'(i);
      cur_useful = (i < 15360) && ((i % 2560) >= 512);
      forever begin
        stb_i = ($urandom_range(99) >= stall_pct);
        @(negedge clk);
        if (stb_i && ack_o) break;
        w++;
        if (w > 1000) begin
          total++;
          bad++;
          $display("FAIL timeout sample=%0d waited=%0d required_ack=1", i, w);
          $display("test done: total=%0d bad=%0d", total, bad);
          $fatal(1, "input handshake stuck");
        end
        @(posedge clk);
        #1;
      end
      if (cur_useful) q.push_back('{32'(i), (i % 2560) == 512, 4'(i / 2560)});
      @(posedge clk);
      #1;
    end
    stb_i = 0;
    cur_useful = 0;
  endtask

  task automatic run_frame(input int n, input int stall, input int ackp, input int e_outs,
                           input int e_done, input int e_err, input int e_drain);
    int w;
    outs = 0; dones = 0; errs = 0; drains = 0;
    ack_pct = ackp;
    stall_pct = stall;
    cyc_i = 1;
    send(n);
    cyc_i = 0;
    w = 0;
    forever begin
      @(negedge clk);
      if (!cyc_o && !stb_o) break;
      w++;
      if (w > 200) break;
    end
    chk("settle", w > 200, 0);
    repeat (3) @(negedge clk);
    chk("outs", outs, e_outs);
    chk("dones", dones, e_done);
    chk("errs", errs, e_err);
    chk("drains", drains, e_drain);
    chk("queue_left", q.size(), 0);
    chk("idle_cyc_o", cyc_o, 0);
    chk("idle_ack_o", ack_o, 0);
    q.delete();
  endtask

  initial begin
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_stb", stb_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_dat", dat_o, 0);
    @(posedge clk);
    #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    ack_pct = 0;
    cyc_i = 1;
    send(513);
    @(negedge clk);
    chk("pre_rst_stb", stb_o, 1);
    chk("pre_rst_ack", ack_o, 0);
    chk("pre_rst_first", sym_first, 1);
    chk("pre_rst_dat", dat_o, 512);
    rst = 1;
    @(posedge clk);
    #1;
    cyc_i = 0;
    @(negedge clk);
    chk("mid_rst_cyc", cyc_o, 0);
    chk("mid_rst_stb", stb_o, 0);
    chk("mid_rst_we", we_o, 0);
    chk("mid_rst_ack", ack_o, 0);
    chk("mid_rst_dat", dat_o, 0);
    chk("mid_rst_first", sym_first, 0);
    chk("mid_rst_idx", sym_idx, 0);
    chk("mid_rst_flags", {frame_done, frame_err}, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    run_frame(15360, 0, 100, 12288, 1, 0, 0);
    run_frame(15360, 0, 50, 12288, 1, 0, 0);
    run_frame(4001, 0, 100, 2048 + 929, 0, 1, 0);
    run_frame(16000, 30, 100, 12288, 1, 0, 640);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
